// File: rtl/uart_8n1_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter between NUM_PORTS byte
// requesters; one grant per frame, next grant only after the frame completes.
module uart_8n1_tx_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic                   clk_baud_16x,
    input  logic                   reset,
    input  logic [NUM_PORTS-1:0]   req_valid,
    input  logic [8*NUM_PORTS-1:0] req_data,
    output logic [NUM_PORTS-1:0]   req_ready,
    output logic [7:0]             trans_data,
    output logic                   trans_write,
    input  logic                   trans_busy,
    output logic                   tx_active,
    output logic [IDX_WIDTH-1:0]   tx_owner
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_DONE  = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [IDX_WIDTH-1:0]   last_grant_r;
    logic [IDX_WIDTH:0]     search_start_s;
    logic [IDX_WIDTH:0]     grant_off_s;
    logic [IDX_WIDTH:0]     grant_sum_s;
    logic [NUM_PORTS-1:0]   valid_rot_s;
    logic [NUM_PORTS-1:0]   scan_s;
    logic                   grant_found_s;
    logic                   grant_fire_s;
    logic [IDX_WIDTH-1:0]   grant_idx_s;
    logic [7:0]             grant_byte_s;

    // Round-robin search: rotate the valid vector so the port after the last
    // grant sits at bit 0, take the first set bit, then map back to a port index.
    always_comb begin
        search_start_s = {1'b0, last_grant_r} + (IDX_WIDTH+1)'(1);
        valid_rot_s    = NUM_PORTS'({req_valid, req_valid} >> search_start_s);
        scan_s         = valid_rot_s;
        grant_found_s  = 1'b0;
        grant_off_s    = {(IDX_WIDTH+1){1'b0}};
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!grant_found_s && scan_s[0]) begin
                grant_found_s = 1'b1;
                grant_off_s   = (IDX_WIDTH+1)'(k);
            end else begin
                grant_found_s = grant_found_s;
            end
            scan_s = scan_s >> 1;
        end
        grant_sum_s = search_start_s + grant_off_s;
        if (grant_sum_s >= (IDX_WIDTH+1)'(NUM_PORTS)) begin
            grant_sum_s = grant_sum_s - (IDX_WIDTH+1)'(NUM_PORTS);
        end else begin
            grant_sum_s = grant_sum_s;
        end
        grant_idx_s  = grant_sum_s[IDX_WIDTH-1:0];
        grant_byte_s = 8'(req_data >> {grant_idx_s, 3'b000});
    end

    // Handshake: ready is only offered from IDLE with the transmitter free.
    always_comb begin
        grant_fire_s = (state_r == ST_IDLE) && !trans_busy && grant_found_s && !reset;
        if (grant_fire_s) begin
            req_ready = NUM_PORTS'(1) << grant_idx_s;
        end else begin
            req_ready = {NUM_PORTS{1'b0}};
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_fire_s) state_next_s = ST_ISSUE;
                else              state_next_s = ST_IDLE;
            end
            ST_ISSUE: begin
                state_next_s = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (trans_busy) state_next_s = ST_WAIT_DONE;
                else            state_next_s = ST_WAIT_START;
            end
            ST_WAIT_DONE: begin
                if (!trans_busy) state_next_s = ST_IDLE;
                else             state_next_s = ST_WAIT_DONE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_baud_16x) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered outputs; the write strobe is high exactly while in ISSUE.
    always_ff @(posedge clk_baud_16x) begin
        if (reset) begin
            trans_write  <= 1'b0;
            trans_data   <= 8'h00;
            tx_active    <= 1'b0;
            tx_owner     <= {IDX_WIDTH{1'b0}};
            last_grant_r <= IDX_WIDTH'(NUM_PORTS - 1);
        end else begin
            trans_write <= grant_fire_s;
            tx_active   <= (state_next_s != ST_IDLE);
            if (grant_fire_s) begin
                trans_data   <= grant_byte_s;
                tx_owner     <= grant_idx_s;
                last_grant_r <= grant_idx_s;
            end
        end
    end

endmodule

// File: tb/tb_uart_8n1_tx_arbiter.sv
// Directed bench for uart_8n1_tx_arbiter with a behavioural transmitter busy model.
module tb_uart_8n1_tx_arbiter;

    localparam int FRAME = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = 4'b0000;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  req_ready;
    logic [7:0]  trans_data;
    logic        trans_write;
    logic        trans_busy;
    logic        tx_active;
    logic [1:0]  tx_owner;

    logic [1:0]  req_valid2 = 2'b00;
    logic [15:0] req_data2 = 16'h0;
    logic [1:0]  req_ready2;
    logic [7:0]  trans_data2;
    logic        trans_write2;
    logic        trans_busy2;
    logic        tx_active2;
    logic [0:0]  tx_owner2;

    int checks = 0;
    int errors = 0;
    int busy_cnt, busy_cnt2;
    int ready_pulses = 0, onehot_errs = 0, overlap_errs = 0;
    logic [7:0] written_q[$];
    logic [7:0] written2_q[$];

    always #5 clk = ~clk;

    uart_8n1_tx_arbiter #(.NUM_PORTS(4), .IDX_WIDTH(2)) dut (
        .clk_baud_16x(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .trans_data(trans_data), .trans_write(trans_write),
        .trans_busy(trans_busy), .tx_active(tx_active), .tx_owner(tx_owner));

    uart_8n1_tx_arbiter #(.NUM_PORTS(2), .IDX_WIDTH(1)) dut2 (
        .clk_baud_16x(clk), .reset(reset), .req_valid(req_valid2), .req_data(req_data2),
        .req_ready(req_ready2), .trans_data(trans_data2), .trans_write(trans_write2),
        .trans_busy(trans_busy2), .tx_active(tx_active2), .tx_owner(tx_owner2));

    // Transmitter models: busy rises the cycle after a write and stays up FRAME cycles.
    always @(posedge clk) begin
        if (reset) begin
            trans_busy <= 1'b0; busy_cnt <= 0;
        end else if (trans_write) begin
            trans_busy <= 1'b1; busy_cnt <= FRAME;
        end else if (trans_busy) begin
            if (busy_cnt == 1) trans_busy <= 1'b0;
            busy_cnt <= busy_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            trans_busy2 <= 1'b0; busy_cnt2 <= 0;
        end else if (trans_write2) begin
            trans_busy2 <= 1'b1; busy_cnt2 <= FRAME;
        end else if (trans_busy2) begin
            if (busy_cnt2 == 1) trans_busy2 <= 1'b0;
            busy_cnt2 <= busy_cnt2 - 1;
        end
    end

    // Monitor: log written bytes and handshake statistics.
    always @(posedge clk) begin
        if (!reset) begin
            if (trans_write) begin
                written_q.push_back(trans_data);
                if (trans_busy) overlap_errs <= overlap_errs + 1;
            end
            if (req_ready != 4'b0000) ready_pulses <= ready_pulses + 1;
            if ($countones(req_ready) > 1) onehot_errs <= onehot_errs + 1;
            if (trans_write2) written2_q.push_back(trans_data2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (trans_busy) begin ok = 1'b1; break; end
            tick();
        end
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (!trans_busy) begin ok = 1'b1; break; end
                tick();
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        req_valid = 4'b0001;
        reset = 1'b1;
        tick(); tick();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected %b", req_ready, 4'b0000); end
        checks++; if (trans_write !== 1'b0) begin errors++; $display("FAIL reset_trans_write: got %b expected 0", trans_write); end
        checks++; if (trans_data !== 8'h00) begin errors++; $display("FAIL reset_trans_data: got %h expected 00", trans_data); end
        checks++; if (tx_active !== 1'b0) begin errors++; $display("FAIL reset_tx_active: got %b expected 0", tx_active); end
        checks++; if (tx_owner !== 2'd0) begin errors++; $display("FAIL reset_tx_owner: got %0d expected 0", tx_owner); end
        req_valid = 4'b0000;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_port();
        bit ok;
        int base = written_q.size();
        int rp = ready_pulses;
        req_data[7:0] = 8'h42;
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected %b", req_ready, 4'b0001); end
        tick();
        req_valid = 4'b0000;
        #1;
        checks++; if (trans_write !== 1'b1) begin errors++; $display("FAIL single_write: got %b expected 1", trans_write); end
        checks++; if (trans_data !== 8'h42) begin errors++; $display("FAIL single_data: got %h expected 42", trans_data); end
        checks++; if (tx_active !== 1'b1) begin errors++; $display("FAIL single_active: got %b expected 1", tx_active); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_off: got %b expected 0000", req_ready); end
        tick();
        checks++; if (trans_write !== 1'b0) begin errors++; $display("FAIL single_write_len: got %b expected 0", trans_write); end
        wait_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_frame_timeout: got timeout expected frame"); end
        checks++; if (tx_active !== 1'b1) begin errors++; $display("FAIL single_active_hold: got %b expected 1", tx_active); end
        tick();
        checks++; if (tx_active !== 1'b0) begin errors++; $display("FAIL single_active_fall: got %b expected 0", tx_active); end
        checks++; if (written_q.size() != base + 1 || ready_pulses != rp + 1) begin errors++; $display("FAIL single_counts: got writes=%0d pulses=%0d expected 1/1", written_q.size() - base, ready_pulses - rp); end
    endtask

    task automatic test_all_contend();
        bit ok;
        int base, rp, oh, ov;
        logic [7:0] exp_b [5];
        exp_b = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        do_reset();
        base = written_q.size(); rp = ready_pulses; oh = onehot_errs; ov = overlap_errs;
        req_data = 32'hA3A2A1A0;
        req_valid = 4'b1111;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (written_q.size() >= base + 5) begin ok = 1'b1; break; end
        end
        req_valid = 4'b0000;
        checks++; if (!ok) begin errors++; $display("FAIL contend_timeout: got %0d writes expected 5", written_q.size() - base); end
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (written_q[base + i] !== exp_b[i]) begin errors++; $display("FAIL contend_order[%0d]: got %h expected %h", i, written_q[base + i], exp_b[i]); end
            end
        end
        checks++; if (tx_owner !== 2'd0) begin errors++; $display("FAIL contend_owner: got %0d expected 0", tx_owner); end
        wait_frame(ok);
        tick();
        checks++; if (ready_pulses != rp + 5) begin errors++; $display("FAIL contend_pulses: got %0d expected 5", ready_pulses - rp); end
        checks++; if (onehot_errs != oh || overlap_errs != ov) begin errors++; $display("FAIL contend_protocol: got onehot=%0d overlap=%0d expected 0/0", onehot_errs - oh, overlap_errs - ov); end
    endtask

    task automatic test_rotation_skip();
        bit ok;
        do_reset();
        req_data = 32'h13000000 | 32'h00001100 | 32'h00000010;
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        wait_frame(ok);
        tick();
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rot_first_ready: got %b expected %b", req_ready, 4'b1000); end
        tick();
        req_valid = 4'b0001;
        checks++; if (tx_owner !== 2'd3 || trans_data !== 8'h13) begin errors++; $display("FAIL rot_first_grant: got owner=%0d data=%h expected 3/13", tx_owner, trans_data); end
        wait_frame(ok);
        tick();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rot_second_ready: got %b expected %b", req_ready, 4'b0001); end
        tick();
        req_valid = 4'b0000;
        checks++; if (tx_owner !== 2'd0 || trans_data !== 8'h10) begin errors++; $display("FAIL rot_second_grant: got owner=%0d data=%h expected 0/10", tx_owner, trans_data); end
        wait_frame(ok);
        tick();
    endtask

    task automatic test_late_request();
        bit ok;
        bit early = 1'b0;
        req_data[15:8] = 8'h21;
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        tick(); tick(); tick();
        req_data[23:16] = 8'hCA;
        req_valid = 4'b0100;
        #1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (req_ready !== 4'b0000) early = 1'b1;
            if (!trans_busy) begin ok = 1'b1; break; end
            tick();
        end
        checks++; if (!ok || early) begin errors++; $display("FAIL late_no_early_grant: got early=%0d ok=%0d expected 0/1", early, ok); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL late_busy_fall_ready: got %b expected 0000", req_ready); end
        tick();
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL late_ready: got %b expected %b", req_ready, 4'b0100); end
        tick();
        req_valid = 4'b0000;
        checks++; if (trans_write !== 1'b1 || trans_data !== 8'hCA || tx_owner !== 2'd2) begin errors++; $display("FAIL late_write: got wr=%b data=%h owner=%0d expected 1/CA/2", trans_write, trans_data, tx_owner); end
        wait_frame(ok);
        tick();
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int base = written_q.size();
        req_data[31:24] = 8'h77;
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b0000;
        tick(); tick(); tick();
        checks++; if (tx_active !== 1'b1 || trans_busy !== 1'b1) begin errors++; $display("FAIL mid_in_frame: got active=%b busy=%b expected 1/1", tx_active, trans_busy); end
        req_data[15:8] = 8'h61;
        req_data[23:16] = 8'h62;
        req_valid = 4'b0110;
        reset = 1'b1;
        tick();
        checks++; if (req_ready !== 4'b0000 || trans_write !== 1'b0 || tx_active !== 1'b0) begin errors++; $display("FAIL mid_reset_ctl: got ready=%b wr=%b active=%b expected 0000/0/0", req_ready, trans_write, tx_active); end
        tick();
        checks++; if (trans_data !== 8'h00 || tx_owner !== 2'd0) begin errors++; $display("FAIL mid_reset_regs: got data=%h owner=%0d expected 00/0", trans_data, tx_owner); end
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_after_ready: got %b expected %b", req_ready, 4'b0010); end
        tick();
        req_valid = 4'b0000;
        checks++; if (tx_owner !== 2'd1 || trans_data !== 8'h61) begin errors++; $display("FAIL mid_after_grant: got owner=%0d data=%h expected 1/61", tx_owner, trans_data); end
        wait_frame(ok);
        tick();
        checks++; if (written_q.size() != base + 2) begin errors++; $display("FAIL mid_write_count: got %0d expected 2", written_q.size() - base); end
    endtask

    task automatic test_two_ports();
        bit ok = 1'b0;
        int base = written2_q.size();
        logic [7:0] exp_b [4];
        exp_b = '{8'h55, 8'hAA, 8'h55, 8'hAA};
        req_data2 = 16'hAA55;
        req_valid2 = 2'b11;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (written2_q.size() >= base + 4) begin ok = 1'b1; break; end
        end
        req_valid2 = 2'b00;
        checks++; if (!ok) begin errors++; $display("FAIL two_timeout: got %0d writes expected 4", written2_q.size() - base); end
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (written2_q[base + i] !== exp_b[i]) begin errors++; $display("FAIL two_alternate[%0d]: got %h expected %h", i, written2_q[base + i], exp_b[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_all_contend();
        test_rotation_skip();
        test_late_request();
        test_reset_mid_frame();
        test_two_ports();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_8n1_tx_arbiter.md
# uart_8n1_tx_arbiter

Round-robin arbiter that shares one `uart_8n1_transmitter` between `NUM_PORTS` byte requesters. Each requester offers a byte with a valid/ready handshake; the arbiter grants one port at a time, latches its byte, issues a single write to the transmitter and holds off further grants until that frame has completed. It sits directly in front of the transmitter and shares its `clk_baud_16x` clock domain.

## Interface
- `NUM_PORTS`, 4, number of requesters; legal range 2..8
- `IDX_WIDTH`, 2, width of the port index; must satisfy 2^IDX_WIDTH >= NUM_PORTS
- `clk_baud_16x`  in  1  sole clock; same clock as the transmitter
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_PORTS  per-port byte offer
- `req_data`  in  8*NUM_PORTS  port i byte on bits [8i+7:8i]
- `req_ready`  out  NUM_PORTS  per-port accept; at most one bit high in any cycle
- `trans_data`  out  8  byte to the transmitter
- `trans_write`  out  1  one-cycle write strobe to the transmitter
- `trans_busy`  in  1  transmitter frame in progress
- `tx_active`  out  1  high whenever the FSM is not in IDLE
- `tx_owner`  out  IDX_WIDTH  index of the last granted port

## Operation
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE.
- IDLE:
  - If any `req_valid` is high and `trans_busy`=0, select the grant port g by round-robin.
  - Assert `req_ready[g]` combinationally in the same cycle; this is the handshake cycle.
  - On that edge: latch the byte into `trans_data`, set `tx_owner`<=g, update the round-robin pointer, go to ISSUE.
- ISSUE: `trans_write`=1 for exactly this cycle, then go to WAIT_START.
- WAIT_START: stay until `trans_busy`=1, then go to WAIT_DONE. There is no timeout.
- WAIT_DONE: stay until `trans_busy`=0, then go to IDLE.
- Round-robin rule:
  - Search starts at (last_grant+1) mod NUM_PORTS and moves upward with wrap-around.
  - The first port with `req_valid` set wins.
  - After reset, last_grant = NUM_PORTS-1, so port 0 has first priority.
- Requester handshake rules:
  - Once asserted, `req_valid` and its data must stay stable until the matching `req_ready`.
  - A deasserted `req_valid` is simply skipped; no penalty.
- `req_ready` is 0 in every state except IDLE.
- `trans_data` holds its value between frames. It changes only on a grant edge.
- Ports with index >= NUM_PORTS do not exist. `tx_owner` never takes such values.

## Timing
- Reset values: state=IDLE, `trans_write`=0, `trans_data`=8'h00, `req_ready`=0, `tx_active`=0, `tx_owner`=0, last_grant=NUM_PORTS-1.
- Latency:
  - `req_valid` seen in IDLE -> `req_ready` high in the same cycle.
  - `trans_write` high on the next cycle.
- The transmitter raises `trans_busy` the cycle after it samples `trans_write`.
- Minimum cycles between grant edges: 3 + frame duration, where the frame duration is the number of cycles `trans_busy` is high.
- Simultaneous events:
  - `trans_busy`=1 while in IDLE (transmitter still finishing): no grant until it is 0.
  - All ports valid at once: exactly one `req_ready` per grant, in rotating order.
- Reset mid-frame: the FSM returns to IDLE on the next edge and all outputs take their reset values. The pending byte is dropped and is not re-offered by the arbiter.
- `tx_active` is registered from state: high from the first cycle after the grant edge until the cycle after `trans_busy` falls.

## Test plan
- **Single port:** reset, then port 0 offers 8'h42 -> `req_ready[0]` for 1 cycle, one `trans_write` pulse with `trans_data`=8'h42, `tx` shows start bit, 0x42 LSB-first, stop bit. `tx_active` falls after `trans_busy` falls.
- **All ports contending:** ports 0..3 hold 8'hA0..8'hA3 continuously -> bytes transmitted in order A0, A1, A2, A3, A0; exactly one `req_ready` per frame; no `trans_write` while `trans_busy`=1.
- **Rotation skips idle ports:** last grant = 1; ports 0 and 3 valid -> port 3 granted first, then port 0.
- **Late request:** port 2 raises 8'hCA during port 1's frame -> granted the first IDLE cycle after `trans_busy` falls; `trans_write` follows 1 cycle later.
- **Reset mid-frame:** assert reset during WAIT_DONE for 2 cycles -> all outputs at reset values, `req_ready`=0. The next request is granted to the lowest valid port index, starting from port 0.
- **NUM_PORTS=2, IDX_WIDTH=1:** both ports always valid with 8'h55 / 8'hAA -> strictly alternating frames.
